// File: rtl/nmi2axi4l_pkg.sv
// nmi2axi4l_pkg
// Shared definitions for the NMI to AXI4-Lite bridge:
//   - AXI4-Lite response codes and protection encodings
//   - nmi_req_t: the NMI request as captured when the bridge accepts it
//   - resp_is_err(): anything other than OKAY is reported to the core as an error
package nmi2axi4l_pkg;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_EXOKAY = 2'b01;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  // Unprivileged, secure accesses; bit 2 marks an instruction fetch.
  localparam logic [2:0] PROT_DATA  = 3'b000;
  localparam logic [2:0] PROT_INSTR = 3'b100;

  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic        instr;
  } nmi_req_t;

  function automatic logic resp_is_err(input logic [1:0] resp);
    return resp != RESP_OKAY;
  endfunction

endpackage

// File: rtl/nmi2axi4l_if.sv
// nmi2axi4l_if
// AXI4-Lite bus between the bridge (master modport) and a slave (slave modport).
// Channels: AW (awaddr/awprot), W (wdata/wstrb), B (bresp), AR (araddr/arprot),
// R (rdata/rresp), each with its valid/ready pair.
//
// Handshake rule on every channel: a transfer happens on the rising clock edge
// where valid and ready are both high. Once valid is raised it, and the channel
// payload, stay unchanged until that edge; ready may be raised or dropped freely.
interface nmi2axi4l_if;

  logic [31:0] awaddr;
  logic [2:0]  awprot;
  logic        awvalid;
  logic        awready;

  logic [31:0] wdata;
  logic [3:0]  wstrb;
  logic        wvalid;
  logic        wready;

  logic [1:0]  bresp;
  logic        bvalid;
  logic        bready;

  logic [31:0] araddr;
  logic [2:0]  arprot;
  logic        arvalid;
  logic        arready;

  logic [31:0] rdata;
  logic [1:0]  rresp;
  logic        rvalid;
  logic        rready;

  modport master (
    output awaddr, awprot, awvalid, input awready,
    output wdata, wstrb, wvalid, input wready,
    input  bresp, bvalid, output bready,
    output araddr, arprot, arvalid, input arready,
    input  rdata, rresp, rvalid, output rready
  );

  modport slave (
    input  awaddr, awprot, awvalid, output awready,
    input  wdata, wstrb, wvalid, output wready,
    output bresp, bvalid, input bready,
    input  araddr, arprot, arvalid, output arready,
    output rdata, rresp, rvalid, input rready
  );

endinterface

// File: rtl/nmi2axi4l.sv
// nmi2axi4l
// Bridge from the native memory interface (NMI) of a simple core to a
// single-outstanding AXI4-Lite master port.
//
// Ports:
//   clk_i, rst_n_i    clock, asynchronous active-low reset
//   mem_valid_i       NMI request, held by the core until mem_ready_o
//   mem_instr_i       instruction fetch flag (drives arprot bit 2)
//   mem_addr_i        byte address
//   mem_wdata_i       write data
//   mem_wstrb_i       byte strobes, 4'b0000 means read
//   mem_rdata_o       read data, valid with mem_ready_o (0 after a write)
//   mem_ready_o       one-cycle registered completion pulse
//   err_o             pulses with mem_ready_o on a non-OKAY response or timeout
//   axi               AXI4-Lite master (nmi2axi4l_if.master)
//   dbg_state_o       current FSM state: 0 IDLE, 1 WR_REQ, 2 WR_RESP,
//                     3 RD_REQ, 4 RD_RESP
//
// Optional build macro NMI2AXI4L_TIMEOUT_EN adds a response watchdog of
// TIMEOUT_CYCLES busy cycles. On expiry the core gets an error completion with
// read data 32'hFFFF_FFFF right away, while the bridge keeps finishing the AXI
// transaction in the background and swallows its completion.
module nmi2axi4l
  import nmi2axi4l_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic        clk_i,
  input  logic        rst_n_i,
  input  logic        mem_valid_i,
  input  logic        mem_instr_i,
  input  logic [31:0] mem_addr_i,
  input  logic [31:0] mem_wdata_i,
  input  logic [3:0]  mem_wstrb_i,
  output logic [31:0] mem_rdata_o,
  output logic        mem_ready_o,
  output logic        err_o,
  nmi2axi4l_if.master axi,
  output logic [2:0]  dbg_state_o
);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_WR_REQ  = 3'd1,
    S_WR_RESP = 3'd2,
    S_RD_REQ  = 3'd3,
    S_RD_RESP = 3'd4
  } state_t;

  state_t      state_q, state_d;
  nmi_req_t    req_q;
  logic        aw_done_q, aw_done_d;
  logic        w_done_q, w_done_d;
  logic        ready_q, ready_d;
  logic        err_q, err_d;
  logic [31:0] rdata_q, rdata_d;
  logic        accept;
  logic        complete;
  logic        aw_hs, w_hs;
  logic        expire;
  logic        aborted_q;

  // Valids and readies are decoded from state so an asynchronous reset clears
  // them immediately. AW and W each drop after their own handshake.
  assign axi.awvalid = (state_q == S_WR_REQ) && !aw_done_q;
  assign axi.wvalid  = (state_q == S_WR_REQ) && !w_done_q;
  assign axi.bready  = (state_q == S_WR_RESP);
  assign axi.arvalid = (state_q == S_RD_REQ);
  assign axi.rready  = (state_q == S_RD_RESP);

  // Payloads come straight from the captured request, so they cannot move
  // while a valid is up.
  assign axi.awaddr = req_q.addr;
  assign axi.awprot = PROT_DATA;
  assign axi.wdata  = req_q.wdata;
  assign axi.wstrb  = req_q.wstrb;
  assign axi.araddr = req_q.addr;
  assign axi.arprot = req_q.instr ? PROT_INSTR : PROT_DATA;

  assign aw_hs = axi.awvalid && axi.awready;
  assign w_hs  = axi.wvalid && axi.wready;

  // The AXI transaction finishes this cycle (B or R handshake).
  assign complete = ((state_q == S_WR_RESP) && axi.bvalid) ||
                    ((state_q == S_RD_RESP) && axi.rvalid);

  assign mem_ready_o = ready_q;
  assign err_o       = err_q;
  assign mem_rdata_o = rdata_q;
  assign dbg_state_o = state_q;

`ifdef NMI2AXI4L_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(TIMEOUT_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  logic [CNT_W-1:0] cnt_q;

  // Expiry is the edge at which the counter reaches TIMEOUT_CYCLES. A real
  // completion in that same cycle takes priority and is reported normally.
  assign expire = (state_q != S_IDLE) && !aborted_q && (cnt_q == CNT_LAST) && !complete;

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      cnt_q     <= '0;
      aborted_q <= 1'b0;
    end else begin
      if (accept) begin
        cnt_q <= '0;
      end else if ((state_q != S_IDLE) && (cnt_q != CNT_MAX)) begin
        cnt_q <= cnt_q + 1'b1;
      end
      // Aborted lasts until the background transaction drains back to IDLE.
      if (complete) begin
        aborted_q <= 1'b0;
      end else if (expire) begin
        aborted_q <= 1'b1;
      end
    end
  end
`else
  logic unused_timeout;

  assign expire         = 1'b0;
  assign aborted_q      = 1'b0;
  assign unused_timeout = (TIMEOUT_CYCLES > 0);
`endif

  always_comb begin
    state_d   = state_q;
    aw_done_d = aw_done_q;
    w_done_d  = w_done_q;
    accept    = 1'b0;
    ready_d   = 1'b0;
    err_d     = 1'b0;
    rdata_d   = rdata_q;
    case (state_q)
      S_IDLE: begin
        // Not in the completion cycle: a still-high mem_valid_i there belongs
        // to the request just finished.
        if (mem_valid_i && !ready_q) begin
          accept    = 1'b1;
          aw_done_d = 1'b0;
          w_done_d  = 1'b0;
          state_d   = (|mem_wstrb_i) ? S_WR_REQ : S_RD_REQ;
        end
      end
      S_WR_REQ: begin
        aw_done_d = aw_done_q || aw_hs;
        w_done_d  = w_done_q || w_hs;
        if (aw_done_d && w_done_d) begin
          state_d = S_WR_RESP;
        end
      end
      S_WR_RESP: begin
        if (axi.bvalid) begin
          state_d = S_IDLE;
          ready_d = 1'b1;
          err_d   = resp_is_err(axi.bresp);
          rdata_d = '0;
        end
      end
      S_RD_REQ: begin
        if (axi.arready) begin
          state_d = S_RD_RESP;
        end
      end
      S_RD_RESP: begin
        if (axi.rvalid) begin
          state_d = S_IDLE;
          ready_d = 1'b1;
          err_d   = resp_is_err(axi.rresp);
          rdata_d = axi.rdata;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    if (aborted_q) begin
      // The core was already answered by the watchdog.
      ready_d = 1'b0;
      err_d   = 1'b0;
      rdata_d = rdata_q;
    end else if (expire) begin
      ready_d = 1'b1;
      err_d   = 1'b1;
      rdata_d = 32'hFFFF_FFFF;
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q   <= S_IDLE;
      req_q     <= '0;
      aw_done_q <= 1'b0;
      w_done_q  <= 1'b0;
      ready_q   <= 1'b0;
      err_q     <= 1'b0;
      rdata_q   <= '0;
    end else begin
      state_q   <= state_d;
      aw_done_q <= aw_done_d;
      w_done_q  <= w_done_d;
      ready_q   <= ready_d;
      err_q     <= err_d;
      rdata_q   <= rdata_d;
      if (accept) begin
        req_q.addr  <= mem_addr_i;
        req_q.wdata <= mem_wdata_i;
        req_q.wstrb <= mem_wstrb_i;
        req_q.instr <= mem_instr_i;
      end
    end
  end

endmodule

// File: tb/tb_nmi2axi4l.sv
// tb_nmi2axi4l
// Bench for nmi2axi4l: directed steps followed by randomized NMI traffic
// against an AXI4-Lite slave with programmable per-channel delays. Expected
// NMI results come from a word-array memory model updated by byte strobes.
// Build with NMI2AXI4L_TIMEOUT_EN defined to add the watchdog step
// (TIMEOUT_CYCLES = 8).
module tb_nmi2axi4l;
  import nmi2axi4l_pkg::*;

`ifdef NMI2AXI4L_TIMEOUT_EN
  localparam int TO_CYCLES = 8;
`else
  localparam int TO_CYCLES = 1024;
`endif

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- DUT ----------------
  logic        mem_valid = 1'b0;
  logic        mem_instr = 1'b0;
  logic [31:0] mem_addr = '0;
  logic [31:0] mem_wdata = '0;
  logic [3:0]  mem_wstrb = '0;
  logic [31:0] mem_rdata;
  logic        mem_ready;
  logic        err;
  logic [2:0]  dbg_state;

  nmi2axi4l_if axi ();

  nmi2axi4l #(.TIMEOUT_CYCLES(TO_CYCLES)) dut (
    .clk_i       (clk),
    .rst_n_i     (rst_n),
    .mem_valid_i (mem_valid),
    .mem_instr_i (mem_instr),
    .mem_addr_i  (mem_addr),
    .mem_wdata_i (mem_wdata),
    .mem_wstrb_i (mem_wstrb),
    .mem_rdata_o (mem_rdata),
    .mem_ready_o (mem_ready),
    .err_o       (err),
    .axi         (axi),
    .dbg_state_o (dbg_state)
  );

  // ---------------- scoreboard state ----------------
  int checks = 0;
  int failures = 0;
  logic [31:0] exp_q[$];
  logic [31:0] exp_err_q[$];
  logic [31:0] ref_mem [16];
  int last_c0 = 0;
  int last_lat = 0;

  function automatic logic [31:0] init_val(input int i);
    return (i == 4) ? 32'hCAFE_0001 : (32'h5A00_0000 + i * 32'h0001_0203);
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $display("FAIL %s observed=%h expected=%h", tag, obs, exp);
      $error("check %s", tag);
    end
  endtask

  // ---------------- AXI slave model ----------------
  int ar_dly = 0, aw_dly = 0, w_dly = 0, b_dly = 0, r_dly = 0;
  logic [1:0] resp_val = RESP_OKAY;
  logic [31:0] slv_mem [16];
  int ar_hs_n = 0, aw_hs_n = 0, w_hs_n = 0, b_hs_n = 0, r_hs_n = 0;
  int ar_cyc = 0, aw_cyc = 0, w_cyc = 0;
  logic [31:0] cap_araddr = '0, cap_awaddr = '0, cap_wdata = '0;
  logic [2:0]  cap_arprot = '0, cap_awprot = '0;
  logic [3:0]  cap_wstrb = '0;
  int proto_err = 0;

  function automatic int total_hs();
    return ar_hs_n + aw_hs_n + w_hs_n + b_hs_n + r_hs_n;
  endfunction

  // Acts on the falling edge: readies set here take effect at the next rising
  // edge, so a handshake is counted when valid and the new ready are both high.
  initial begin
    bit rd_pend, wr_pend, aw_got, w_got;
    int ar_cnt, aw_cnt, w_cnt, b_cnt, r_cnt, rd_idx;
    rd_pend = 0; wr_pend = 0; aw_got = 0; w_got = 0;
    ar_cnt = 0; aw_cnt = 0; w_cnt = 0; b_cnt = 0; r_cnt = 0; rd_idx = 0;
    for (int i = 0; i < 16; i++) slv_mem[i] = init_val(i);
    axi.awready = 1'b0; axi.wready = 1'b0; axi.bvalid = 1'b0; axi.bresp = '0;
    axi.arready = 1'b0; axi.rvalid = 1'b0; axi.rdata = '0; axi.rresp = '0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        rd_pend = 0; wr_pend = 0; aw_got = 0; w_got = 0;
        ar_cnt = 0; aw_cnt = 0; w_cnt = 0; b_cnt = 0; r_cnt = 0;
        axi.awready = 1'b0; axi.wready = 1'b0; axi.bvalid = 1'b0;
        axi.arready = 1'b0; axi.rvalid = 1'b0;
        continue;
      end
      if (axi.bready && !(aw_got && w_got)) proto_err++;
      if (axi.awvalid && aw_got) proto_err++;
      if (axi.wvalid && w_got) proto_err++;
      // R
      if (rd_pend) begin
        if (r_cnt >= r_dly) begin
          axi.rvalid = 1'b1; axi.rdata = slv_mem[rd_idx]; axi.rresp = resp_val;
          if (axi.rready) begin r_hs_n++; rd_pend = 0; end
        end else begin
          axi.rvalid = 1'b0; r_cnt++;
        end
      end else axi.rvalid = 1'b0;
      // AR
      if (axi.arvalid) begin
        if (ar_cnt >= ar_dly) begin
          axi.arready = 1'b1; ar_hs_n++; ar_cyc = cyc;
          cap_araddr = axi.araddr; cap_arprot = axi.arprot;
          rd_idx = int'(axi.araddr[5:2]); rd_pend = 1; r_cnt = 0; ar_cnt = 0;
        end else begin
          axi.arready = 1'b0; ar_cnt++;
        end
      end else begin
        axi.arready = 1'b0; ar_cnt = 0;
      end
      // B
      if (wr_pend) begin
        if (b_cnt >= b_dly) begin
          axi.bvalid = 1'b1; axi.bresp = resp_val;
          if (axi.bready) begin
            b_hs_n++;
            for (int b = 0; b < 4; b++)
              if (cap_wstrb[b]) slv_mem[cap_awaddr[5:2]][8*b +: 8] = cap_wdata[8*b +: 8];
            wr_pend = 0; aw_got = 0; w_got = 0;
          end
        end else begin
          axi.bvalid = 1'b0; b_cnt++;
        end
      end else axi.bvalid = 1'b0;
      // AW
      if (axi.awvalid && !aw_got) begin
        if (aw_cnt >= aw_dly) begin
          axi.awready = 1'b1; aw_hs_n++; aw_cyc = cyc; aw_got = 1; aw_cnt = 0;
          cap_awaddr = axi.awaddr; cap_awprot = axi.awprot;
        end else begin
          axi.awready = 1'b0; aw_cnt++;
        end
      end else axi.awready = 1'b0;
      // W
      if (axi.wvalid && !w_got) begin
        if (w_cnt >= w_dly) begin
          axi.wready = 1'b1; w_hs_n++; w_cyc = cyc; w_got = 1; w_cnt = 0;
          cap_wdata = axi.wdata; cap_wstrb = axi.wstrb;
        end else begin
          axi.wready = 1'b0; w_cnt++;
        end
      end else axi.wready = 1'b0;
      if (aw_got && w_got && !wr_pend) begin
        wr_pend = 1; b_cnt = 0;
      end
    end
  end

  // ---------------- NMI driver ----------------
  task automatic nmi_req(input logic [31:0] addr, input logic [31:0] wdata,
                         input logic [3:0] strb, input logic instr, input bit hold,
                         output logic [31:0] rd, output logic er, output int lat);
    @(posedge clk); #1;
    mem_valid = 1'b1; mem_addr = addr; mem_wdata = wdata; mem_wstrb = strb; mem_instr = instr;
    last_c0 = cyc;
    lat = -1; rd = '0; er = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(posedge clk); #1;
      if (mem_ready) begin
        lat = cyc - last_c0; rd = mem_rdata; er = err;
        break;
      end
    end
    if (lat < 0) begin
      checks++; failures++;
      $display("FAIL nmi_wait observed=no_ready expected=ready_within_100");
    end
    if (!hold) begin mem_valid = 1'b0; mem_wstrb = '0; end
    @(posedge clk); #1;
    mem_valid = 1'b0; mem_wstrb = '0;
    check("ready_single_pulse", {31'd0, mem_ready}, 32'd0);
  endtask

  // One NMI transaction checked against the reference memory.
  task automatic run_txn(input string tag, input logic [31:0] addr, input logic [31:0] wdata,
                         input logic [3:0] strb, input logic instr, input bit hold);
    int idx;
    int hs0;
    logic [31:0] rd;
    logic er;
    int lat;
    idx = int'(addr[5:2]);
    hs0 = total_hs();
    if (strb == 4'b0000) begin
      exp_q.push_back(ref_mem[idx]);
    end else begin
      for (int b = 0; b < 4; b++)
        if (strb[b]) ref_mem[idx][8*b +: 8] = wdata[8*b +: 8];
      exp_q.push_back(32'd0);
    end
    exp_err_q.push_back({31'd0, resp_val != RESP_OKAY});
    nmi_req(addr, wdata, strb, instr, hold, rd, er, lat);
    last_lat = lat;
    check({tag, "_rdata"}, rd, exp_q.pop_front());
    check({tag, "_err"}, {31'd0, er}, exp_err_q.pop_front());
    check({tag, "_axi_hs"}, total_hs() - hs0, (strb == 4'b0000) ? 32'd2 : 32'd3);
    if (strb == 4'b0000) begin
      check({tag, "_araddr"}, cap_araddr, addr);
      check({tag, "_arprot"}, {29'd0, cap_arprot}, instr ? 32'd4 : 32'd0);
    end else begin
      check({tag, "_awaddr"}, cap_awaddr, addr);
      check({tag, "_wdata"}, cap_wdata, wdata);
      check({tag, "_wstrb"}, {28'd0, cap_wstrb}, {28'd0, strb});
      check({tag, "_awprot"}, {29'd0, cap_awprot}, 32'd0);
    end
  endtask

  task automatic set_dly(input int a, input int w, input int b, input int ar, input int r);
    aw_dly = a; w_dly = w; b_dly = b; ar_dly = ar; r_dly = r;
  endtask

  // ---------------- directed + random sequence ----------------
  initial begin
    int hs0;
    bit got;
    int pulses;
    logic [31:0] rd;
    logic er;
    int lat;
    for (int i = 0; i < 16; i++) ref_mem[i] = init_val(i);

    // Reset values, checked with no clock edge since reset is asynchronous.
    #2 rst_n = 1'b0;
    #1;
    check("rst_valids", {27'd0, axi.awvalid, axi.wvalid, axi.arvalid, axi.bready, axi.rready}, 32'd0);
    check("rst_mem_ready", {31'd0, mem_ready}, 32'd0);
    check("rst_err", {31'd0, err}, 32'd0);
    check("rst_rdata", mem_rdata, 32'd0);
    check("rst_awaddr", axi.awaddr, 32'd0);
    check("rst_araddr", axi.araddr, 32'd0);
    check("rst_wdata", axi.wdata, 32'd0);
    check("rst_wstrb", {28'd0, axi.wstrb}, 32'd0);
    check("rst_state", {29'd0, dbg_state}, 32'd0);
    repeat (2) @(negedge clk);
    #1 rst_n = 1'b1;
    repeat (2) @(posedge clk);

    // Zero-wait read.
    set_dly(0, 0, 0, 0, 0); resp_val = RESP_OKAY;
    run_txn("rd_zero_wait", 32'h4000_0010, 32'd0, 4'b0000, 1'b0, 1'b0);
    check("rd_zero_wait_ar_cycle", ar_cyc - last_c0, 32'd1);
    check("rd_zero_wait_latency", last_lat, 32'd3);

    // Write with AWREADY two cycles ahead of WREADY.
    set_dly(0, 2, 0, 0, 0);
    run_txn("wr_split", 32'h4000_0020, 32'h1234_5678, 4'b0011, 1'b0, 1'b0);
    check("wr_split_w_after_aw", w_cyc - aw_cyc, 32'd2);
    check("wr_split_protocol", proto_err, 32'd0);

    // Read returning SLVERR, as an instruction fetch.
    set_dly(0, 0, 0, 0, 0); resp_val = RESP_SLVERR;
    run_txn("rd_slverr_instr", 32'h4000_0024, 32'd0, 4'b0000, 1'b1, 1'b0);
    resp_val = RESP_OKAY;

    // mem_valid held through the completion cycle must not start a new access.
    run_txn("rd_held", 32'h4000_0008, 32'd0, 4'b0000, 1'b0, 1'b1);
    hs0 = total_hs();
    repeat (4) @(posedge clk);
    #1;
    check("held_no_retrigger", total_hs(), hs0);
    check("held_state_idle", {29'd0, dbg_state}, 32'd0);

    // mem_valid dropped after acceptance: the transaction still completes.
    set_dly(0, 0, 0, 1, 3);
    @(posedge clk); #1;
    mem_valid = 1'b1; mem_addr = 32'h4000_001C; mem_wstrb = 4'b0000; mem_instr = 1'b0;
    @(posedge clk); #1;
    mem_valid = 1'b0;
    got = 0; rd = '0;
    for (int i = 0; i < 30; i++) begin
      @(posedge clk); #1;
      if (mem_ready) begin got = 1; rd = mem_rdata; break; end
    end
    check("drop_ready_seen", {31'd0, got}, 32'd1);
    check("drop_rdata", rd, ref_mem[7]);

    // Randomized traffic.
    for (int n = 0; n < 40; n++) begin
      int idx;
      int r;
      logic [3:0] strb;
      logic [31:0] wd;
      logic instr;
      idx = $urandom_range(0, 15);
      strb = ($urandom_range(0, 1) == 1) ? 4'($urandom_range(1, 15)) : 4'b0000;
      wd = $urandom;
      instr = (strb == 4'b0000) ? 1'($urandom_range(0, 1)) : 1'b0;
      set_dly($urandom_range(0, 2), $urandom_range(0, 2), $urandom_range(0, 2),
              $urandom_range(0, 2), $urandom_range(0, 2));
      r = $urandom_range(0, 5);
      resp_val = (r < 3) ? RESP_OKAY : 2'(r - 2);
      run_txn("rand", 32'h4000_0000 | (idx << 2), wd, strb, instr, 1'b0);
    end
    resp_val = RESP_OKAY;
    check("rand_protocol", proto_err, 32'd0);

`ifdef NMI2AXI4L_TIMEOUT_EN
    // Watchdog: slave answers long after expiry; the late R is drained silently.
    set_dly(0, 0, 0, 0, 14);
    hs0 = r_hs_n;
    nmi_req(32'h4000_0030, 32'd0, 4'b0000, 1'b0, 1'b0, rd, er, lat);
    check("to_latency", lat, 32'd9);
    check("to_rdata", rd, 32'hFFFF_FFFF);
    check("to_err", {31'd0, er}, 32'd1);
    pulses = 0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk); #1;
      if (mem_ready) pulses++;
    end
    check("to_drained", r_hs_n - hs0, 32'd1);
    check("to_no_late_pulse", pulses, 32'd0);
    check("to_state_idle", {29'd0, dbg_state}, 32'd0);
    set_dly(0, 0, 0, 0, 0);
    run_txn("to_after", 32'h4000_0030, 32'd0, 4'b0000, 1'b0, 1'b0);
`endif

    // Reset while stuck in the write request phase.
    set_dly(10, 10, 0, 0, 0);
    @(posedge clk); #1;
    mem_valid = 1'b1; mem_addr = 32'h4000_0004; mem_wdata = 32'hDEAD_BEEF; mem_wstrb = 4'b1111;
    repeat (2) @(posedge clk);
    #1;
    check("wr_stall_awvalid", {30'd0, axi.awvalid, axi.wvalid}, 32'd3);
    #2 rst_n = 1'b0;
    #1;
    check("midrst_valids", {27'd0, axi.awvalid, axi.wvalid, axi.arvalid, axi.bready, axi.rready}, 32'd0);
    check("midrst_state", {29'd0, dbg_state}, 32'd0);
    mem_valid = 1'b0; mem_wstrb = '0;
    repeat (2) @(negedge clk);
    #1 rst_n = 1'b1;
    set_dly(0, 0, 0, 0, 0);
    run_txn("post_rst_rd", 32'h4000_0004, 32'd0, 4'b0000, 1'b0, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Absolute guard so the run always ends.
  initial begin
    #200000;
    $display("FAIL global_timeout observed=running expected=finished");
    $fatal(1, "global timeout");
  end

endmodule
